// File: rtl/pc_fetch_unit.sv
// Program counter for the Otter fetch stage: six-source next-PC mux, imem handshake,
// configurable reset vector and misaligned-target rejection.
module pc_fetch_unit #(
  parameter int unsigned   n         = 32,
  parameter logic [n-1:0]  RESET_VEC = '0,
  parameter int unsigned   ALIGN     = 2
) (
  input  logic         CLK,
  input  logic         rst,
  input  logic         PC_WE,
  input  logic [2:0]   PC_SEL,
  input  logic [n-1:0] jalr,
  input  logic [n-1:0] branch,
  input  logic [n-1:0] jal,
  input  logic [n-1:0] mtvec,
  input  logic [n-1:0] mepc,
  input  logic         imem_ack,
  output logic [n-1:0] PC,
  output logic [n-1:0] PC_PLUS4,
  output logic         imem_req,
  output logic         fetch_valid,
  output logic         misaligned,
  output logic [n-1:0] bad_addr
);

  localparam logic [n-1:0] AlignMask = n'((64'd1 << ALIGN) - 64'd1);
  localparam logic [n-1:0] JalrMask  = n'(64'd1);

  typedef enum logic [0:0] {StReq, StReady} state_e;

  state_e       r_state;
  logic [n-1:0] r_pc;
  logic [n-1:0] r_bad_addr;
  logic         r_misaligned;

  logic [n-1:0] w_plus4;
  logic [n-1:0] w_next;
  logic         w_hold;
  logic         w_next_misaligned;

  assign w_plus4 = r_pc + n'(32'd4);

  always_comb begin
    w_next = r_pc;
    w_hold = 1'b0;
    unique case (PC_SEL)
      3'd0:    w_next = w_plus4;
      3'd1:    w_next = jalr & ~JalrMask;
      3'd2:    w_next = branch;
      3'd3:    w_next = jal;
      // CSR targets are force-aligned so a trap entry/return can never fault
      3'd4:    w_next = mtvec & ~AlignMask;
      3'd5:    w_next = mepc & ~AlignMask;
      default: w_hold = 1'b1;
    endcase
  end

  assign w_next_misaligned = !w_hold && ((w_next & AlignMask) != '0);

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_pc         <= RESET_VEC;
      r_state      <= StReq;
      r_bad_addr   <= '0;
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= 1'b0;
      case (r_state)
        StReq: begin
          if (imem_ack) r_state <= StReady;
        end
        StReady: begin
          if (PC_WE) begin
            if (w_next_misaligned) begin
              r_misaligned <= 1'b1;
              r_bad_addr   <= w_next;
            end else begin
              // hold sources keep PC but still refetch
              r_pc    <= w_next;
              r_state <= StReq;
            end
          end
        end
        default: r_state <= StReq;
      endcase
    end
  end

  assign PC          = r_pc;
  assign PC_PLUS4    = w_plus4;
  assign imem_req    = !rst && (r_state == StReq);
  assign fetch_valid = !rst && (r_state == StReady);
  assign misaligned  = r_misaligned;
  assign bad_addr    = r_bad_addr;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: two instances (ALIGN=2 and ALIGN=1) share stimulus,
// each checked every cycle against its own behavioural model.
module tb_pc_fetch_unit;

  localparam logic [31:0] RV = 32'h100;

  logic        CLK = 1'b0;
  logic        d_rst = 1'b1;
  logic        d_we = 1'b0;
  logic [2:0]  d_sel = 3'd0;
  logic [31:0] d_jalr = '0, d_branch = '0, d_jal = '0, d_mtvec = '0, d_mepc = '0;
  logic        d_ack = 1'b0;

  logic [31:0] pc0, plus0, bad0, pc1, plus1, bad1;
  logic        req0, val0, mis0, req1, val1, mis1;

  always #5 CLK = ~CLK;

  pc_fetch_unit #(.n(32), .RESET_VEC(RV), .ALIGN(2)) u_dut0 (
    .CLK(CLK), .rst(d_rst), .PC_WE(d_we), .PC_SEL(d_sel), .jalr(d_jalr), .branch(d_branch),
    .jal(d_jal), .mtvec(d_mtvec), .mepc(d_mepc), .imem_ack(d_ack), .PC(pc0),
    .PC_PLUS4(plus0), .imem_req(req0), .fetch_valid(val0), .misaligned(mis0), .bad_addr(bad0)
  );

  pc_fetch_unit #(.n(32), .RESET_VEC(RV), .ALIGN(1)) u_dut1 (
    .CLK(CLK), .rst(d_rst), .PC_WE(d_we), .PC_SEL(d_sel), .jalr(d_jalr), .branch(d_branch),
    .jal(d_jal), .mtvec(d_mtvec), .mepc(d_mepc), .imem_ack(d_ack), .PC(pc1),
    .PC_PLUS4(plus1), .imem_req(req1), .fetch_valid(val1), .misaligned(mis1), .bad_addr(bad1)
  );

  typedef struct {
    logic [31:0] pc, plus4, bad;
    logic        req, valid, mis;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state, one slot per instance
  int unsigned m_align[2] = '{2, 1};
  logic [31:0] m_pc[2];
  logic [31:0] m_bad[2];
  bit          m_ready[2];
  bit          m_mis[2];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] force_align(input logic [31:0] v, input int unsigned a);
    return v - (v % (32'd1 << a));
  endfunction

  // Advance model k across one rising edge using the inputs held during the ending cycle
  task automatic model_edge(input int k);
    logic [31:0] tgt;
    if (d_rst) begin
      m_pc[k] = RV; m_ready[k] = 0; m_bad[k] = 0; m_mis[k] = 0;
    end else begin
      m_mis[k] = 0;
      if (!m_ready[k]) begin
        if (d_ack) m_ready[k] = 1;
      end else if (d_we) begin
        case (d_sel)
          3'd0: tgt = m_pc[k] + 32'd4;
          3'd1: tgt = d_jalr - (d_jalr % 2);
          3'd2: tgt = d_branch;
          3'd3: tgt = d_jal;
          3'd4: tgt = force_align(d_mtvec, m_align[k]);
          3'd5: tgt = force_align(d_mepc, m_align[k]);
          default: tgt = m_pc[k];
        endcase
        if (d_sel >= 3'd6) m_ready[k] = 0;
        else if ((tgt % (32'd1 << m_align[k])) != 0) begin
          m_mis[k] = 1; m_bad[k] = tgt;
        end else begin
          m_pc[k] = tgt; m_ready[k] = 0;
        end
      end
    end
  endtask

  function automatic exp_t model_out(input int k);
    exp_t e;
    e.pc = m_pc[k]; e.plus4 = m_pc[k] + 32'd4; e.bad = m_bad[k]; e.mis = m_mis[k];
    e.req = !d_rst && !m_ready[k];
    e.valid = !d_rst && m_ready[k];
    return e;
  endfunction

  // One cycle: cross the edge, then drive this cycle's inputs and queue the expected outputs
  task automatic cyc(input bit rst_v, input bit we, input logic [2:0] sel, input bit ack,
                     input logic [31:0] j, input logic [31:0] b, input logic [31:0] jl,
                     input logic [31:0] mt, input logic [31:0] me);
    @(posedge CLK);
    model_edge(0);
    model_edge(1);
    #1;
    d_rst = rst_v; d_we = we; d_sel = sel; d_ack = ack;
    d_jalr = j; d_branch = b; d_jal = jl; d_mtvec = mt; d_mepc = me;
    exp_q0.push_back(model_out(0));
    exp_q1.push_back(model_out(1));
  endtask

  task automatic idle(input bit ack);
    cyc(0, 0, 3'd0, ack, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 10 && !m_ready[0]; i++) idle(1);
    if (!m_ready[0]) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_ready: got REQ expected READY within 10 cycles");
    end
  endtask

  task automatic issue(input logic [2:0] sel, input logic [31:0] tgt, input logic [31:0] exp_pc,
                       input string name);
    wait_ready();
    cyc(0, 1, sel, 0, tgt, tgt, tgt, tgt, tgt);
    idle(0);
    @(negedge CLK);
    cmp({name, "_pc"}, pc0, exp_pc);
    cmp({name, "_mis"}, {31'd0, mis0}, 32'd0);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      cmp("a2_pc", pc0, e.pc);       cmp("a2_pc_plus4", plus0, e.plus4);
      cmp("a2_bad_addr", bad0, e.bad);
      cmp("a2_imem_req", {31'd0, req0}, {31'd0, e.req});
      cmp("a2_fetch_valid", {31'd0, val0}, {31'd0, e.valid});
      cmp("a2_misaligned", {31'd0, mis0}, {31'd0, e.mis});
    end
    if (exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      cmp("a1_pc", pc1, e.pc);       cmp("a1_pc_plus4", plus1, e.plus4);
      cmp("a1_bad_addr", bad1, e.bad);
      cmp("a1_imem_req", {31'd0, req1}, {31'd0, e.req});
      cmp("a1_fetch_valid", {31'd0, val1}, {31'd0, e.valid});
      cmp("a1_misaligned", {31'd0, mis1}, {31'd0, e.mis});
    end
  end

  initial begin
    // Reset/boot
    cyc(1, 0, 3'd0, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 3'd0, 1, 0, 0, 0, 0, 0);
    @(negedge CLK);
    cmp("rst_imem_req", {31'd0, req0}, 32'd0);
    idle(1);
    @(negedge CLK);
    cmp("boot_pc", pc0, 32'h100);
    cmp("boot_imem_req", {31'd0, req0}, 32'd1);

    // Sequential run, PC_WE held through REQ cycles
    for (int i = 0; i < 6; i++) cyc(0, 1, 3'd0, 1, 0, 0, 0, 0, 0);
    @(negedge CLK);
    cmp("seq_pc", pc0, 32'h10C);

    // Jumps and traps
    issue(3'd3, 32'h200, 32'h200, "jal");
    issue(3'd1, 32'h305, 32'h304, "jalr");
    issue(3'd4, 32'h403, 32'h400, "mtvec");
    issue(3'd5, 32'h1006, 32'h1004, "mepc");

    // Misaligned branch: ALIGN=2 rejects, ALIGN=1 takes it
    issue(3'd3, 32'h200, 32'h200, "jal2");
    wait_ready();
    cyc(0, 1, 3'd2, 0, 0, 32'h202, 0, 0, 0);
    idle(0);
    @(negedge CLK);
    cmp("mis_pc_held", pc0, 32'h200);
    cmp("mis_pulse", {31'd0, mis0}, 32'd1);
    cmp("mis_bad_addr", bad0, 32'h202);
    cmp("mis_fetch_valid", {31'd0, val0}, 32'd1);
    cmp("align1_pc", pc1, 32'h202);
    idle(0);
    @(negedge CLK);
    cmp("mis_pulse_end", {31'd0, mis0}, 32'd0);

    // Wrap then stall
    issue(3'd3, 32'hFFFF_FFFC, 32'hFFFF_FFFC, "jal_top");
    wait_ready();
    cyc(0, 1, 3'd0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      idle(0);
      @(negedge CLK);
      cmp("wrap_pc", pc0, 32'h0);
      cmp("stall_imem_req", {31'd0, req0}, 32'd1);
      cmp("stall_fetch_valid", {31'd0, val0}, 32'd0);
    end
    idle(1);
    idle(0);
    @(negedge CLK);
    cmp("stall_release_valid", {31'd0, val0}, 32'd1);

    // Reset mid-request with ack
    cyc(0, 1, 3'd0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 3'd0, 1, 0, 0, 0, 0, 0);
    @(negedge CLK);
    cmp("midrst_imem_req", {31'd0, req0}, 32'd0);
    idle(0);
    @(negedge CLK);
    cmp("midrst_pc", pc0, RV);
    cmp("midrst_imem_req_after", {31'd0, req0}, 32'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] base;
      base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FF00 : 32'h0;
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 1) == 1),
          3'($urandom_range(0, 7)), ($urandom_range(0, 9) < 6),
          base | ($urandom & 32'hFFF), base | ($urandom & 32'hFFF), base | ($urandom & 32'hFFF),
          $urandom, $urandom);
    end
    idle(0);
    @(negedge CLK);
    #1;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL drain: got %0d entries left expected 0", exp_q0.size() + exp_q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
